// File: rtl/imem_dmem_port_arbiter_if.sv
// Bundle between the fetch/data stages, the port arbiter and the shared memory.
// The slave view belongs to the arbiter; the master view belongs to the stages and the memory.
interface imem_dmem_port_arbiter_if;
  logic        IF_Req;
  logic [31:0] IF_Addr;
  logic        IF_Flush;
  logic [31:0] IF_Instr;
  logic        IF_Valid;
  logic        IF_Stall;
  logic        D_Req;
  logic        D_Write;
  logic [31:0] D_Addr;
  logic [31:0] D_WData;
  logic [31:0] D_RData;
  logic        D_Done;
  logic        D_Stall;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Mem_RData;

  modport slave (
    input  IF_Req, IF_Addr, IF_Flush, D_Req, D_Write, D_Addr, D_WData, Mem_RData,
    output IF_Instr, IF_Valid, IF_Stall, D_RData, D_Done, D_Stall,
           Mem_Addr, Mem_WData, Mem_Read, Mem_Write
  );

  modport master (
    output IF_Req, IF_Addr, IF_Flush, D_Req, D_Write, D_Addr, D_WData, Mem_RData,
    input  IF_Instr, IF_Valid, IF_Stall, D_RData, D_Done, D_Stall,
           Mem_Addr, Mem_WData, Mem_Read, Mem_Write
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates a single fixed-latency memory port between instruction fetch and data access,
// with data priority bounded by a streak limit so fetch cannot starve.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate this cycle
// BUSY_I | fetch access on the memory port, strobes held
// BUSY_D | load/store access on the memory port, strobes held
// RESP_I | one-cycle fetch response (IF_Valid unless flushed)
// RESP_D | one-cycle data response (D_Done)
module imem_dmem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                       CLK,
  input  logic                       RESET,
  imem_dmem_port_arbiter_if.slave    bus
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   lat_cnt;
  logic [SW-1:0]   streak;
  logic [31:0]     addr_q, wdata_q, fetch_buf, if_instr_q, d_rdata_q;
  logic            write_q, flush_q;
  logic            grant_d, grant_i, if_valid, last_beat;

  assign last_beat = (lat_cnt == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.D_Req && !(bus.IF_Req && streak == STREAK_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.IF_Req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I:  if (last_beat) state_nxt = RESP_I;
      BUSY_D:  if (last_beat) state_nxt = RESP_D;
      RESP_I:  state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_cnt    <= '0;
      streak     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      flush_q    <= 1'b0;
      fetch_buf  <= '0;
      if_instr_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_d || grant_i) begin
        lat_cnt <= LAT_LOAD;
        flush_q <= 1'b0;
        write_q <= grant_d && bus.D_Write;
        addr_q  <= grant_d ? bus.D_Addr : bus.IF_Addr;
      end else if ((state == BUSY_I || state == BUSY_D) && !last_beat) begin
        lat_cnt <= lat_cnt - CW'(1);
      end

      if (grant_d) begin
        wdata_q <= bus.D_WData;
        if (!bus.IF_Req)              streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + SW'(1);
      end else if (grant_i) begin
        streak <= '0;
      end

      if (state == BUSY_I && bus.IF_Flush) flush_q <= 1'b1;

      if (state == BUSY_I && last_beat)             fetch_buf <= bus.Mem_RData;
      if (state == BUSY_D && last_beat && !write_q) d_rdata_q <= bus.Mem_RData;
      // the visible instruction register only advances on a delivered (unflushed) fetch
      if (if_valid) if_instr_q <= fetch_buf;
    end
  end

  assign if_valid = (state == RESP_I) && !flush_q && !bus.IF_Flush;

  assign bus.IF_Valid  = if_valid;
  assign bus.IF_Instr  = if_valid ? fetch_buf : if_instr_q;
  assign bus.IF_Stall  = bus.IF_Req && !if_valid;
  assign bus.D_Done    = (state == RESP_D);
  assign bus.D_RData   = d_rdata_q;
  assign bus.D_Stall   = bus.D_Req && (state != RESP_D);
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_WData = wdata_q;
  assign bus.Mem_Read  = (state == BUSY_I) || (state == BUSY_D && !write_q);
  assign bus.Mem_Write = (state == BUSY_D) && write_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for the imem/dmem port arbiter: fetch, load, store, priority,
// anti-starvation, flush and asynchronous reset, with hand-computed expectations.
module tb_imem_dmem_port_arbiter;
  localparam int LAT = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  imem_dmem_port_arbiter_if bus();

  imem_dmem_port_arbiter #(.LATENCY(LAT), .MAX_D_STREAK(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at cycle 0 with the fetch request already driven and the arbiter idle.
  task automatic expect_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    #4;
    check_val({tag, "_stall_c0"}, bus.IF_Stall, 1);
    check_val({tag, "_rd_c0"}, bus.Mem_Read, 0);
    for (int c = 1; c <= LAT; c++) begin
      cyc(); #4;
      check_val({tag, "_rd_busy"}, bus.Mem_Read, 1);
      check_val({tag, "_addr_busy"}, bus.Mem_Addr, addr);
      check_val({tag, "_valid_busy"}, bus.IF_Valid, 0);
      check_val({tag, "_stall_busy"}, bus.IF_Stall, 1);
    end
    cyc(); #4;
    check_val({tag, "_valid"}, bus.IF_Valid, 1);
    check_val({tag, "_instr"}, bus.IF_Instr, word);
    check_val({tag, "_stall_resp"}, bus.IF_Stall, 0);
    check_val({tag, "_rd_resp"}, bus.Mem_Read, 0);
    check_val({tag, "_done_resp"}, bus.D_Done, 0);
  endtask

  initial begin
    int  d_cnt, lim;
    bit  got_if, nxt_d, fin, saw_d;

    bus.IF_Req = 0; bus.IF_Addr = '0; bus.IF_Flush = 0;
    bus.D_Req = 0; bus.D_Write = 0; bus.D_Addr = '0; bus.D_WData = '0;
    bus.Mem_RData = '0;

    // reset state
    repeat (3) @(posedge CLK);
    #5;
    check_val("rst_rd", bus.Mem_Read, 0);
    check_val("rst_wr", bus.Mem_Write, 0);
    check_val("rst_addr", bus.Mem_Addr, 0);
    check_val("rst_instr", bus.IF_Instr, 0);
    check_val("rst_rdata", bus.D_RData, 0);
    check_val("rst_valid", bus.IF_Valid, 0);
    check_val("rst_done", bus.D_Done, 0);
    RESET = 0;

    // fetch only
    cyc();
    bus.IF_Req = 1; bus.IF_Addr = 32'hBFC00000; bus.Mem_RData = 32'h3C080001;
    expect_fetch("t1", 32'hBFC00000, 32'h3C080001);
    cyc(); bus.IF_Req = 0;

    // simultaneous fetch and load: data first
    cyc();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      if (c == 0) begin
        bus.IF_Req = 1; bus.IF_Addr = 32'h00400000;
        bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 32'h80000020;
        bus.Mem_RData = 32'h12345678;
      end
      if (c == 4) begin
        bus.D_Req = 0; bus.Mem_RData = 32'h11112222;
      end
      #4;
      if (c == 1 || c == 2) begin
        check_val("t2_d_rd", bus.Mem_Read, 1);
        check_val("t2_d_addr", bus.Mem_Addr, 32'h80000020);
        check_val("t2_d_stall", bus.D_Stall, 1);
        check_val("t2_i_stall", bus.IF_Stall, 1);
      end
      if (c == 3) begin
        check_val("t2_done", bus.D_Done, 1);
        check_val("t2_rdata", bus.D_RData, 32'h12345678);
        check_val("t2_d_stall_resp", bus.D_Stall, 0);
        check_val("t2_valid_early", bus.IF_Valid, 0);
      end
      if (c == 4) check_val("t2_idle_rd", bus.Mem_Read, 0);
      if (c == 5 || c == 6) check_val("t2_i_addr", bus.Mem_Addr, 32'h00400000);
      if (c == 7) begin
        check_val("t2_valid", bus.IF_Valid, 1);
        check_val("t2_instr", bus.IF_Instr, 32'h11112222);
      end
    end
    cyc(); bus.IF_Req = 0;

    // sustained data traffic: streak limit lets the fetch in after three grants
    cyc();
    bus.IF_Req = 1; bus.IF_Addr = 32'h00400080;
    bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 32'h80000100;
    bus.Mem_RData = 32'h0BADF00D;
    d_cnt = 0; got_if = 0; nxt_d = 0; fin = 0; lim = 0;
    while (!fin && lim < 80) begin
      #4;
      saw_d = bus.D_Done;
      if (bus.D_Done) begin
        if (!got_if) d_cnt++;
        else begin nxt_d = 1; fin = 1; end
      end
      if (bus.IF_Valid) begin
        if (got_if) fin = 1;
        got_if = 1;
      end
      cyc();
      lim++;
      if (saw_d) bus.D_Addr = bus.D_Addr + 32'd4;
    end
    bus.IF_Req = 0; bus.D_Req = 0;
    check_val("t3_streak", d_cnt, 3);
    check_val("t3_fetch_in", got_if, 1);
    check_val("t3_data_resumes", nxt_d, 1);
    cyc(); cyc();

    // flush during a fetch
    bus.IF_Req = 1; bus.IF_Addr = 32'h00400100; bus.Mem_RData = 32'h99999999;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      bus.IF_Flush = (c == 2);
      #4;
      if (c == 1 || c == 2) check_val("t4_rd", bus.Mem_Read, 1);
      if (c == 3) begin
        check_val("t4_valid", bus.IF_Valid, 0);
        check_val("t4_instr", bus.IF_Instr, 32'h0BADF00D);
        check_val("t4_stall", bus.IF_Stall, 1);
        check_val("t4_rd_resp", bus.Mem_Read, 0);
      end
    end
    cyc();
    bus.IF_Addr = 32'hA0000180; bus.Mem_RData = 32'h27BDFFE8;
    expect_fetch("t4b", 32'hA0000180, 32'h27BDFFE8);
    cyc(); bus.IF_Req = 0;

    // store
    cyc();
    bus.D_Req = 1; bus.D_Write = 1; bus.D_Addr = 32'h80000010; bus.D_WData = 32'hDEADBEEF;
    bus.Mem_RData = 32'h55555555;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      #4;
      if (c == 1 || c == 2) begin
        check_val("t5_wr", bus.Mem_Write, 1);
        check_val("t5_rd", bus.Mem_Read, 0);
        check_val("t5_addr", bus.Mem_Addr, 32'h80000010);
        check_val("t5_wdata", bus.Mem_WData, 32'hDEADBEEF);
      end
      if (c == 3) begin
        check_val("t5_done", bus.D_Done, 1);
        check_val("t5_rdata_kept", bus.D_RData, 32'h0BADF00D);
        check_val("t5_wr_resp", bus.Mem_Write, 0);
      end
    end
    cyc(); bus.D_Req = 0; bus.D_Write = 0;

    // reset in the middle of a store
    cyc();
    bus.D_Req = 1; bus.D_Write = 1; bus.D_Addr = 32'h80000040; bus.D_WData = 32'h12121212;
    cyc(); #4;
    check_val("t6_wr_pre", bus.Mem_Write, 1);
    RESET = 1;
    #1;
    check_val("t6_wr_drop", bus.Mem_Write, 0);
    check_val("t6_addr", bus.Mem_Addr, 0);
    check_val("t6_wdata", bus.Mem_WData, 0);
    check_val("t6_done", bus.D_Done, 0);
    check_val("t6_rdata", bus.D_RData, 0);
    check_val("t6_instr", bus.IF_Instr, 0);
    bus.D_Req = 0; bus.D_Write = 0;
    bus.IF_Req = 1; bus.IF_Addr = 32'h00000100; bus.Mem_RData = 32'h24020005;
    repeat (2) begin
      cyc(); #4;
      check_val("t6_no_done", bus.D_Done, 0);
      check_val("t6_no_valid", bus.IF_Valid, 0);
    end
    cyc();
    RESET = 0;
    expect_fetch("t6f", 32'h00000100, 32'h24020005);
    cyc(); bus.IF_Req = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
